mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage consumer of the EX/MEM pipeline register. Takes the latched ALU result,
//  store data and control bits, and runs the data-memory access over a req/ack handshake
//  that can take several cycles. Stalls the upstream pipeline while an access is
//  outstanding, then presents one result per instruction to the MEM/WB register.
// PARAMETERS
//  DATA_W    32  width of data, address and ALU result
//  MAX_WAIT  15  max cycles dm_req stays high without dm_ack before timeout (>=1)
// PORTS
//  clk            in   1       pipeline clock, rising edge
//  reset          in   1       asynchronous, active-low reset
//  ex_valid       in   1       EX/MEM holds a valid instruction
//  ex_alu_result  in   DATA_W  ALU result / memory address
//  ex_mem_wr_data in   DATA_W  store data
//  ex_wr_reg      in   5       destination register
//  ex_c_reg_write in   1       instruction writes the register file
//  ex_c_mem_to_reg in  1       writeback value comes from memory
//  ex_c_mem_read  in   1       load
//  ex_c_mem_write in   1       store
//  mem_stall      out  1       upstream must hold EX/MEM; instruction not consumed
//  dm_req         out  1       data-memory request
//  dm_we          out  1       1 = write, 0 = read
//  dm_addr        out  DATA_W  word address (low 2 bits always 0)
//  dm_wdata       out  DATA_W  write data
//  dm_rdata       in   DATA_W  read data, valid when dm_ack=1
//  dm_ack         in   1       access complete
//  wb_valid       out  1       one-cycle pulse: result for MEM/WB
//  wb_data        out  DATA_W  writeback value
//  wb_reg         out  5       destination register
//  wb_reg_write   out  1       register-file write enable, 0 when wb_valid=0
//  mem_err        out  1       sticky error (misaligned access or timeout)
// BEHAVIOUR
//  - Reset (reset=0): state IDLE, wait_cnt=0. All outputs go to 0 immediately.
//    Any in-flight access is dropped.
//  - States: IDLE, ACCESS. mem_stall = (state==ACCESS), combinational.
//  - Consume: an instruction is consumed when ex_valid=1 and state==IDLE at a rising edge.
//    ex_valid is ignored in ACCESS.
//  - Consumed non-memory op (read=write=0): after the edge, wb_valid=1,
//    wb_data=ex_alu_result and wb_reg/wb_reg_write are passed through. Latency 1.
//  - Consumed memory op with ex_alu_result[1:0]!=0: no request. After the edge,
//    wb_valid=1, wb_reg_write=0 and mem_err=1.
//  - Consumed aligned memory op: state goes to ACCESS. The unit captures address, wdata,
//    wr_reg and the control bits. dm_req=1, dm_we=ex_c_mem_write, wait_cnt=0.
//    If read and write are both set, write wins.
//  - ACCESS: dm_req, dm_we, dm_addr and dm_wdata stay stable. dm_ack is sampled every
//    edge, including the first edge after dm_req rises.
//    - On ack: dm_req=0 and state goes to IDLE. wb_valid=1.
//      wb_data = (load && mem_to_reg) ? dm_rdata : captured ALU result.
//      wb_reg_write = captured reg_write.
//    - On no ack: wait_cnt increments. If wait_cnt==MAX_WAIT-1, timeout: dm_req=0,
//      state goes to IDLE, wb_valid=1, wb_reg_write=0, mem_err=1.
//    - dm_req is therefore high for at most MAX_WAIT cycles.
//  - Latency for memory ops: at least 2 cycles from consume to wb_valid.
//    The next instruction is consumable in the cycle wb_valid is high.
//  - dm_ack while IDLE is ignored.
//  - wb_data and wb_reg hold their last values when wb_valid=0.
//  - mem_err is cleared only by reset.
// TESTING
//  1. ALU op alu=0x00001234, rd=5, rw=1 -> next cycle wb_valid=1, wb_data=0x1234,
//     wb_reg=5, wb_reg_write=1. mem_stall stays 0.
//  2. Load addr 0x100, ack on 3rd req cycle, rdata=0xDEADBEEF -> dm_req and mem_stall
//     high 3 cycles, then wb_valid=1 with wb_data=0xDEADBEEF.
//  3. Store addr 0x40, wdata 0xA5A5A5A5, ack first cycle -> dm_we=1 for 1 cycle,
//     wb_valid next cycle with wb_reg_write=0.
//  4. Load addr 0x102 -> dm_req never rises, mem_err=1, wb_valid=1 with wb_reg_write=0.
//  5. MAX_WAIT=4, load, no ack -> dm_req high exactly 4 cycles, then mem_err=1, wb_valid=1.
//     A following ALU op completes normally.
//  6. reset=0 mid-ACCESS -> dm_req, mem_stall and wb_valid go to 0 immediately.
//     After release, back-to-back load/ALU ops complete.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: consumes EX/MEM instructions, runs the
// req/ack memory handshake with a timeout, and emits one MEM/WB result per instruction.
module mem_access_unit #(
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_mem_wr_data,
  input  logic [4:0]        ex_wr_reg,
  input  logic              ex_c_reg_write,
  input  logic              ex_c_mem_to_reg,
  input  logic              ex_c_mem_read,
  input  logic              ex_c_mem_write,
  output logic              mem_stall,
  output logic              dm_req,
  output logic              dm_we,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  input  logic              dm_ack,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [4:0]        wb_reg,
  output logic              wb_reg_write,
  output logic              mem_err
);

  localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [4:0]        wr_reg_q, wr_reg_d;
  logic              reg_write_q, reg_write_d;
  logic              mem_to_reg_q, mem_to_reg_d;
  logic              load_q, load_d;
  logic              we_q, we_d;
  logic              wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [4:0]        wb_reg_q, wb_reg_d;
  logic              wb_reg_write_q, wb_reg_write_d;
  logic              mem_err_q, mem_err_d;

  logic consume, is_mem, misaligned, start, timeout;

  assign consume    = ex_valid && (state_q == IDLE);
  assign is_mem     = ex_c_mem_read || ex_c_mem_write;
  assign misaligned = is_mem && (ex_alu_result[1:0] != 2'b00);
  assign start      = consume && is_mem && !misaligned;
  assign timeout    = !dm_ack && (wait_cnt_q == LAST_WAIT);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (start) state_d = ACCESS;
      ACCESS: if (dm_ack || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    wait_cnt_d     = wait_cnt_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    wr_reg_d       = wr_reg_q;
    reg_write_d    = reg_write_q;
    mem_to_reg_d   = mem_to_reg_q;
    load_d         = load_q;
    we_d           = we_q;
    wb_valid_d     = 1'b0;
    wb_data_d      = wb_data_q;
    wb_reg_d       = wb_reg_q;
    wb_reg_write_d = 1'b0;
    mem_err_d      = mem_err_q;
    if (state_q == IDLE) begin
      if (consume && !is_mem) begin
        wb_valid_d     = 1'b1;
        wb_data_d      = ex_alu_result;
        wb_reg_d       = ex_wr_reg;
        wb_reg_write_d = ex_c_reg_write;
      end else if (consume && misaligned) begin
        wb_valid_d = 1'b1;
        wb_data_d  = ex_alu_result;
        wb_reg_d   = ex_wr_reg;
        mem_err_d  = 1'b1;
      end else if (start) begin
        addr_d       = ex_alu_result;
        wdata_d      = ex_mem_wr_data;
        wr_reg_d     = ex_wr_reg;
        reg_write_d  = ex_c_reg_write;
        mem_to_reg_d = ex_c_mem_to_reg;
        // A store-and-load encoding is treated as a store.
        load_d       = ex_c_mem_read && !ex_c_mem_write;
        we_d         = ex_c_mem_write;
        wait_cnt_d   = '0;
      end
    end else if (dm_ack) begin
      wb_valid_d     = 1'b1;
      wb_data_d      = (load_q && mem_to_reg_q) ? dm_rdata : addr_q;
      wb_reg_d       = wr_reg_q;
      wb_reg_write_d = reg_write_q;
    end else if (timeout) begin
      wb_valid_d = 1'b1;
      wb_data_d  = addr_q;
      wb_reg_d   = wr_reg_q;
      mem_err_d  = 1'b1;
    end else begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q     <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      wr_reg_q       <= '0;
      reg_write_q    <= 1'b0;
      mem_to_reg_q   <= 1'b0;
      load_q         <= 1'b0;
      we_q           <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_data_q      <= '0;
      wb_reg_q       <= '0;
      wb_reg_write_q <= 1'b0;
      mem_err_q      <= 1'b0;
    end else begin
      wait_cnt_q     <= wait_cnt_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      wr_reg_q       <= wr_reg_d;
      reg_write_q    <= reg_write_d;
      mem_to_reg_q   <= mem_to_reg_d;
      load_q         <= load_d;
      we_q           <= we_d;
      wb_valid_q     <= wb_valid_d;
      wb_data_q      <= wb_data_d;
      wb_reg_q       <= wb_reg_d;
      wb_reg_write_q <= wb_reg_write_d;
      mem_err_q      <= mem_err_d;
    end
  end

  always_comb begin
    dm_req       = (state_q == ACCESS);
    mem_stall    = dm_req;
    dm_we        = dm_req && we_q;
    dm_addr      = {addr_q[DATA_W-1:2], 2'b00};
    dm_wdata     = wdata_q;
    wb_valid     = wb_valid_q;
    wb_data      = wb_data_q;
    wb_reg       = wb_reg_q;
    wb_reg_write = wb_reg_write_q;
    mem_err      = mem_err_q;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios followed by random
// instruction streams checked against a per-instruction outcome model.
module tb_mem_access_unit;

  localparam int DW = 32;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ex_valid = 1'b0;
  logic [DW-1:0] ex_alu_result = '0;
  logic [DW-1:0] ex_mem_wr_data = '0;
  logic [4:0]    ex_wr_reg = '0;
  logic          ex_c_reg_write = 1'b0;
  logic          ex_c_mem_to_reg = 1'b0;
  logic          ex_c_mem_read = 1'b0;
  logic          ex_c_mem_write = 1'b0;
  logic          mem_stall, dm_req, dm_we;
  logic [DW-1:0] dm_addr, dm_wdata;
  logic [DW-1:0] dm_rdata = '0;
  logic          dm_ack = 1'b0;
  logic          wb_valid;
  logic [DW-1:0] wb_data;
  logic [4:0]    wb_reg;
  logic          wb_reg_write, mem_err;

  mem_access_unit #(.DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid),
    .ex_alu_result(ex_alu_result), .ex_mem_wr_data(ex_mem_wr_data),
    .ex_wr_reg(ex_wr_reg), .ex_c_reg_write(ex_c_reg_write),
    .ex_c_mem_to_reg(ex_c_mem_to_reg), .ex_c_mem_read(ex_c_mem_read),
    .ex_c_mem_write(ex_c_mem_write), .mem_stall(mem_stall), .dm_req(dm_req),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .dm_ack(dm_ack), .wb_valid(wb_valid), .wb_data(wb_data), .wb_reg(wb_reg),
    .wb_reg_write(wb_reg_write), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference state: sticky error and the last writeback values, when defined.
  logic          err_exp = 1'b0;
  logic [DW-1:0] last_data = '0;
  logic [4:0]    last_reg = '0;
  bit            data_known = 1'b1;
  bit            reg_known = 1'b1;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // One instruction from issue to writeback; delay = req cycle carrying the ack
  // (a delay beyond MW means the memory never answers).
  task automatic do_op(input logic [DW-1:0] alu, input logic [DW-1:0] wd, input logic [4:0] rd,
                       input logic rw, input logic m2r, input logic rdf, input logic wrf,
                       input int delay, input logic [DW-1:0] rdata);
    bit is_mem, mis, acked, done;
    int n, exp_n;
    is_mem = rdf || wrf;
    mis    = is_mem && (alu[1:0] != 2'b00);
    @(negedge clk);
    chk("stall_at_issue", mem_stall, 1'b0);
    ex_alu_result = alu; ex_mem_wr_data = wd; ex_wr_reg = rd;
    ex_c_reg_write = rw; ex_c_mem_to_reg = m2r; ex_c_mem_read = rdf; ex_c_mem_write = wrf;
    ex_valid = 1'b1;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    ex_alu_result = $urandom; ex_mem_wr_data = $urandom; ex_wr_reg = 5'($urandom);
    if (!is_mem) begin
      chk("alu_wb_valid", wb_valid, 1'b1);
      chk("alu_wb_data", wb_data, alu);
      chk("alu_wb_reg", wb_reg, rd);
      chk("alu_wb_reg_write", wb_reg_write, rw);
      chk("alu_no_stall", mem_stall, 1'b0);
      chk("alu_no_req", dm_req, 1'b0);
      last_data = alu; last_reg = rd; data_known = 1; reg_known = 1;
    end else if (mis) begin
      err_exp = 1'b1;
      chk("mis_wb_valid", wb_valid, 1'b1);
      chk("mis_wb_reg_write", wb_reg_write, 1'b0);
      chk("mis_no_req", dm_req, 1'b0);
      chk("mis_no_stall", mem_stall, 1'b0);
      data_known = 0; reg_known = 0;
    end else begin
      n = 0; done = 0;
      while (!done) begin
        chk("acc_req", dm_req, 1'b1);
        chk("acc_stall", mem_stall, 1'b1);
        chk("acc_we", dm_we, wrf);
        chk("acc_addr", dm_addr, alu);
        chk("acc_wdata", dm_wdata, wd);
        chk("acc_wb_idle", wb_valid, 1'b0);
        n++;
        dm_ack = (n == delay);
        dm_rdata = (n == delay) ? rdata : DW'($urandom);
        @(posedge clk); #1;
        dm_ack = 1'b0;
        if (wb_valid === 1'b1 || n >= MW + 4) done = 1;
      end
      acked = (delay <= MW);
      exp_n = acked ? delay : MW;
      chk("req_cycles", n, exp_n);
      chk("end_wb_valid", wb_valid, 1'b1);
      chk("end_req_low", dm_req, 1'b0);
      chk("end_stall_low", mem_stall, 1'b0);
      if (acked) begin
        chk("ack_wb_reg_write", wb_reg_write, rw);
        chk("ack_wb_data", wb_data, (rdf && !wrf && m2r) ? rdata : alu);
        chk("ack_wb_reg", wb_reg, rd);
        last_data = (rdf && !wrf && m2r) ? rdata : alu;
        last_reg = rd; data_known = 1; reg_known = 1;
      end else begin
        err_exp = 1'b1;
        chk("tmo_wb_reg_write", wb_reg_write, 1'b0);
        data_known = 0; reg_known = 0;
      end
    end
    chk("mem_err", mem_err, err_exp);
  endtask

  // Quiet cycle after an op; optionally strobes dm_ack, which must be ignored.
  task automatic idle_check(input bit poke_ack);
    @(posedge clk); #1;
    chk("idle_wb_valid", wb_valid, 1'b0);
    chk("idle_wb_reg_write", wb_reg_write, 1'b0);
    if (data_known) chk("idle_wb_data_hold", wb_data, last_data);
    if (reg_known) chk("idle_wb_reg_hold", wb_reg, last_reg);
    dm_ack = poke_ack; dm_rdata = $urandom;
    @(posedge clk); #1;
    dm_ack = 1'b0;
    chk("idle_ack_ignored_wb", wb_valid, 1'b0);
    chk("idle_ack_ignored_req", dm_req, 1'b0);
    chk("idle_stall", mem_stall, 1'b0);
    chk("idle_mem_err", mem_err, err_exp);
  endtask

  initial begin
    logic [DW-1:0] a;
    int kind;
    #2 reset = 1'b0;
    #1;
    chk("rst_req", dm_req, 1'b0);
    chk("rst_stall", mem_stall, 1'b0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_mem_err", mem_err, 1'b0);
    chk("rst_wb_data", wb_data, '0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;

    do_op(32'h0000_1234, 32'h0, 5'd5, 1, 0, 0, 0, 1, 32'h0);
    idle_check(1'b1);
    do_op(32'h0000_0100, 32'h0, 5'd7, 1, 1, 1, 0, 3, 32'hDEAD_BEEF);
    do_op(32'h0000_0040, 32'hA5A5_A5A5, 5'd3, 0, 0, 0, 1, 1, 32'h0);
    idle_check(1'b0);
    do_op(32'h0000_0102, 32'h0, 5'd9, 1, 1, 1, 0, 1, 32'h0);
    do_op(32'h0000_0200, 32'h0, 5'd4, 1, 1, 1, 0, 99, 32'h0);
    do_op(32'h0000_00AA, 32'h0, 5'd6, 1, 0, 0, 0, 1, 32'h0);
    do_op(32'h0000_0300, 32'h1111_2222, 5'd8, 1, 1, 1, 1, 4, 32'h3333_4444);

    // Asynchronous reset in the middle of an access.
    @(negedge clk);
    ex_alu_result = 32'h0000_0400; ex_c_mem_read = 1; ex_c_mem_write = 0; ex_valid = 1;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    chk("pre_rst_req", dm_req, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_req", dm_req, 1'b0);
    chk("midrst_stall", mem_stall, 1'b0);
    chk("midrst_wb_valid", wb_valid, 1'b0);
    chk("midrst_mem_err", mem_err, 1'b0);
    @(negedge clk) reset = 1'b1;
    err_exp = 1'b0; last_data = '0; last_reg = '0; data_known = 1; reg_known = 1;
    do_op(32'h0000_0500, 32'h0, 5'd10, 1, 1, 1, 0, 2, 32'hCAFE_F00D);
    do_op(32'h0000_0777, 32'h0, 5'd11, 1, 0, 0, 0, 1, 32'h0);

    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 4);
      a = $urandom;
      case (kind)
        0: do_op(a, $urandom, 5'($urandom), 1'($urandom), 1'($urandom), 0, 0, 1, 0);
        1: do_op(a & 32'hFFFF_FFFC, $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
                 1, 0, $urandom_range(1, 6), $urandom);
        2: do_op(a & 32'hFFFF_FFFC, $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
                 0, 1, $urandom_range(1, 6), $urandom);
        3: do_op(a & 32'hFFFF_FFFC, $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
                 1, 1, $urandom_range(1, 6), $urandom);
        default: do_op((a & 32'hFFFF_FFFC) | DW'($urandom_range(1, 3)), $urandom,
                       5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1, 1, 0);
      endcase
      if ($urandom_range(0, 3) == 0) idle_check(1'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
